// File: rtl/fetch_stage_if.sv
// Instruction SRAM bus between the fetch stage and a synchronous SRAM.
// Read data returns one cycle after the address is presented.
interface fetch_stage_if;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en,
        output inst_sram_addr,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_addr,
        output inst_sram_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// PC generation and IF/ID register for the 5-stage MIPS pipeline.
// Holds the SRAM word across D stalls since the SRAM only returns it once.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stallF,
    input  logic         stallD,
    input  logic         flushD,
    input  logic         branch_takenD,
    input  logic [31:0]  branch_targetD,
    input  logic         jumpD,
    input  logic [31:0]  jump_targetD,
    input  logic         is_bjD,
    input  logic         exc_flush,
    input  logic [31:0]  exc_pc,
    fetch_stage_if.master ibus,
    output logic [31:0]  pcF,
    output logic [31:0]  instrD,
    output logic [31:0]  pcD,
    output logic [31:0]  pc_plus4D,
    output logic         validD,
    output logic         in_dsD,
    output logic         adelD
);

    logic [31:0] pc_plus4F;
    logic [31:0] pc_next;
    logic [31:0] hold;
    logic        hold_valid;
    logic        flush;

    assign pc_plus4F = pcF + 32'd4;
    assign flush     = exc_flush | flushD;

    assign ibus.inst_sram_addr = pcF;
    assign ibus.inst_sram_en   = ~rst & (pcF[1:0] == 2'b00);

    // A redirect while stallF is high is dropped; hazard logic keeps it in D.
    always_comb begin
        pc_next = pc_plus4F;
        if (exc_flush)
            pc_next = exc_pc;
        else if (stallF)
            pc_next = pcF;
        else if (jumpD)
            pc_next = jump_targetD;
        else if (branch_takenD)
            pc_next = branch_targetD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcF <= RESET_PC;
        else
            pcF <= pc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcD        <= 32'd0;
            pc_plus4D  <= 32'd0;
            validD     <= 1'b0;
            in_dsD     <= 1'b0;
            adelD      <= 1'b0;
            hold       <= 32'd0;
            hold_valid <= 1'b0;
        end else if (flush) begin
            validD     <= 1'b0;
            in_dsD     <= 1'b0;
            adelD      <= 1'b0;
            hold_valid <= 1'b0;
        end else if (stallD) begin
            if (!hold_valid) begin
                hold       <= ibus.inst_sram_rdata;
                hold_valid <= 1'b1;
            end
        end else begin
            pcD        <= pcF;
            pc_plus4D  <= pc_plus4F;
            validD     <= 1'b1;
            adelD      <= (pcF[1:0] != 2'b00);
            in_dsD     <= is_bjD & validD;
            hold_valid <= 1'b0;
        end
    end

    always_comb begin
        instrD = ibus.inst_sram_rdata;
        if (!validD || adelD)
            instrD = NOP_WORD;
        else if (hold_valid)
            instrD = hold;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural synchronous SRAM.
// SRAM word at address a is a ^ 32'h1234_5678.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stallF, stallD, flushD;
    logic        branch_takenD, jumpD, is_bjD, exc_flush;
    logic [31:0] branch_targetD, jump_targetD, exc_pc;
    logic [31:0] pcF, instrD, pcD, pc_plus4D;
    logic        validD, in_dsD, adelD;

    int passed;
    int total;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .stallD         (stallD),
        .flushD         (flushD),
        .branch_takenD  (branch_takenD),
        .branch_targetD (branch_targetD),
        .jumpD          (jumpD),
        .jump_targetD   (jump_targetD),
        .is_bjD         (is_bjD),
        .exc_flush      (exc_flush),
        .exc_pc         (exc_pc),
        .ibus           (bus.master),
        .pcF            (pcF),
        .instrD         (instrD),
        .pcD            (pcD),
        .pc_plus4D      (pc_plus4D),
        .validD         (validD),
        .in_dsD         (in_dsD),
        .adelD          (adelD)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial bus.inst_sram_rdata = 32'd0;
    always @(posedge clk)
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= word(bus.inst_sram_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallF = 0; stallD = 0; flushD = 0;
        branch_takenD = 0; jumpD = 0; is_bjD = 0; exc_flush = 0;
        branch_targetD = 0; jump_targetD = 0; exc_pc = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        #2 rst = 1;
        #1;
        total++; if (pcF !== 32'hBFC0_0000)
            $display("FAIL rst_pcF got %h want bfc00000", pcF); else passed++;
        total++; if (pcD !== 32'd0 || pc_plus4D !== 32'd0)
            $display("FAIL rst_pcD got %h/%h want 0/0", pcD, pc_plus4D); else passed++;
        total++; if ({validD, in_dsD, adelD} !== 3'b000)
            $display("FAIL rst_flags got %b want 000", {validD, in_dsD, adelD}); else passed++;
        total++; if (instrD !== 32'd0)
            $display("FAIL rst_instrD got %h want 0", instrD); else passed++;
        total++; if (bus.inst_sram_en !== 1'b0)
            $display("FAIL rst_en got %b want 0", bus.inst_sram_en); else passed++;
        @(negedge clk);
        rst = 0;
        #1;
        total++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'hBFC0_0000)
            $display("FAIL rel_en got %b/%h want 1/bfc00000",
                     bus.inst_sram_en, bus.inst_sram_addr); else passed++;
        tick();
        total++; if (pcD !== 32'hBFC0_0000 || pcF !== 32'hBFC0_0004)
            $display("FAIL first_pc got %h/%h want bfc00000/bfc00004", pcD, pcF); else passed++;
        total++; if (instrD !== word(32'hBFC0_0000) || validD !== 1'b1)
            $display("FAIL first_instr got %h/%b want %h/1",
                     instrD, validD, word(32'hBFC0_0000)); else passed++;
        total++; if (pc_plus4D !== 32'hBFC0_0004)
            $display("FAIL first_p4 got %h want bfc00004", pc_plus4D); else passed++;
    endtask

    task automatic test_stall();
        tick();
        stallF = 1; stallD = 1;
        total++; if (instrD !== word(32'hBFC0_0004))
            $display("FAIL stall0_instr got %h want %h", instrD, word(32'hBFC0_0004)); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (instrD !== word(32'hBFC0_0004))
                $display("FAIL stall_instr[%0d] got %h want %h",
                         i, instrD, word(32'hBFC0_0004)); else passed++;
            total++; if (pcF !== 32'hBFC0_0008 || pcD !== 32'hBFC0_0004)
                $display("FAIL stall_pc[%0d] got %h/%h want bfc00008/bfc00004",
                         i, pcF, pcD); else passed++;
        end
        stallF = 0; stallD = 0;
        tick();
        total++; if (pcD !== 32'hBFC0_0008 || instrD !== word(32'hBFC0_0008))
            $display("FAIL unstall1 got %h/%h want bfc00008/%h",
                     pcD, instrD, word(32'hBFC0_0008)); else passed++;
        tick();
        total++; if (pcD !== 32'hBFC0_000C || instrD !== word(32'hBFC0_000C))
            $display("FAIL unstall2 got %h/%h want bfc0000c/%h",
                     pcD, instrD, word(32'hBFC0_000C)); else passed++;
    endtask

    task automatic test_branch();
        tick();
        total++; if (pcD !== 32'hBFC0_0010 || pcF !== 32'hBFC0_0014)
            $display("FAIL br_setup got %h/%h want bfc00010/bfc00014", pcD, pcF); else passed++;
        is_bjD = 1; branch_takenD = 1; branch_targetD = 32'hBFC0_0100;
        tick();
        is_bjD = 0; branch_takenD = 0;
        total++; if (pcD !== 32'hBFC0_0014 || in_dsD !== 1'b1 || pcF !== 32'hBFC0_0100)
            $display("FAIL br_ds got %h/%b/%h want bfc00014/1/bfc00100",
                     pcD, in_dsD, pcF); else passed++;
        tick();
        total++; if (pcD !== 32'hBFC0_0100 || in_dsD !== 1'b0 || instrD !== word(32'hBFC0_0100))
            $display("FAIL br_tgt got %h/%b/%h want bfc00100/0/%h",
                     pcD, in_dsD, instrD, word(32'hBFC0_0100)); else passed++;
    endtask

    task automatic test_priority();
        jumpD = 1; jump_targetD = 32'hBFC0_0200;
        branch_takenD = 1; branch_targetD = 32'hBFC0_0300; is_bjD = 1;
        tick();
        total++; if (pcF !== 32'hBFC0_0200)
            $display("FAIL jmp_over_br got %h want bfc00200", pcF); else passed++;
        stallF = 1; stallD = 1; jump_targetD = 32'hBFC0_0400;
        tick();
        total++; if (pcF !== 32'hBFC0_0200)
            $display("FAIL stallF_redirect got %h want bfc00200", pcF); else passed++;
        clear_inputs();
        tick();
        total++; if (pcF !== 32'hBFC0_0204 || pcD !== 32'hBFC0_0200)
            $display("FAIL prio_resume got %h/%h want bfc00204/bfc00200", pcF, pcD); else passed++;
    endtask

    task automatic test_exception();
        stallF = 1; stallD = 1;
        exc_flush = 1; exc_pc = 32'hBFC0_0380;
        tick();
        clear_inputs();
        total++; if (pcF !== 32'hBFC0_0380 || validD !== 1'b0 || instrD !== 32'd0)
            $display("FAIL exc got %h/%b/%h want bfc00380/0/0", pcF, validD, instrD); else passed++;
        total++; if (bus.inst_sram_en !== 1'b1)
            $display("FAIL exc_en got %b want 1", bus.inst_sram_en); else passed++;
        tick();
        total++; if (pcD !== 32'hBFC0_0380 || validD !== 1'b1 || instrD !== word(32'hBFC0_0380))
            $display("FAIL exc_fetch got %h/%b/%h want bfc00380/1/%h",
                     pcD, validD, instrD, word(32'hBFC0_0380)); else passed++;
    endtask

    task automatic test_misaligned();
        jumpD = 1; jump_targetD = 32'hBFC0_0202; is_bjD = 1;
        tick();
        clear_inputs();
        total++; if (pcF !== 32'hBFC0_0202 || bus.inst_sram_en !== 1'b0)
            $display("FAIL mis_en got %h/%b want bfc00202/0", pcF, bus.inst_sram_en); else passed++;
        tick();
        total++; if (pcD !== 32'hBFC0_0202 || adelD !== 1'b1 || instrD !== 32'd0)
            $display("FAIL mis_adel got %h/%b/%h want bfc00202/1/0", pcD, adelD, instrD); else passed++;
        total++; if (validD !== 1'b1 || pcF !== 32'hBFC0_0206)
            $display("FAIL mis_valid got %b/%h want 1/bfc00206", validD, pcF); else passed++;
    endtask

    task automatic test_flush_stall();
        exc_flush = 1; exc_pc = 32'hBFC0_0500;
        tick();
        clear_inputs();
        tick();
        total++; if (pcD !== 32'hBFC0_0500 || adelD !== 1'b0)
            $display("FAIL fs_setup got %h/%b want bfc00500/0", pcD, adelD); else passed++;
        stallF = 1; stallD = 1;
        tick();
        total++; if (dut.hold_valid !== 1'b1 || instrD !== word(32'hBFC0_0500))
            $display("FAIL fs_hold got %b/%h want 1/%h",
                     dut.hold_valid, instrD, word(32'hBFC0_0500)); else passed++;
        flushD = 1;
        tick();
        total++; if (validD !== 1'b0 || dut.hold_valid !== 1'b0 || instrD !== 32'd0)
            $display("FAIL fs_flush got %b/%b/%h want 0/0/0",
                     validD, dut.hold_valid, instrD); else passed++;
        clear_inputs();
        tick();
        total++; if (pcD !== 32'hBFC0_0504 || validD !== 1'b1 || instrD !== word(32'hBFC0_0504))
            $display("FAIL fs_resume got %h/%b/%h want bfc00504/1/%h",
                     pcD, validD, instrD, word(32'hBFC0_0504)); else passed++;
    endtask

    task automatic test_wrap();
        exc_flush = 1; exc_pc = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        tick();
        total++; if (pcF !== 32'd0 || pcD !== 32'hFFFF_FFFC || pc_plus4D !== 32'd0)
            $display("FAIL wrap got %h/%h/%h want 0/fffffffc/0", pcF, pcD, pc_plus4D); else passed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1;
        #1;
        total++; if (pcF !== 32'hBFC0_0000 || validD !== 1'b0 || bus.inst_sram_en !== 1'b0)
            $display("FAIL async_rst got %h/%b/%b want bfc00000/0/0",
                     pcF, validD, bus.inst_sram_en); else passed++;
        rst = 0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_stall();
        test_branch();
        test_priority();
        test_exception();
        test_misaligned();
        test_flush_stall();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC generation plus the IF/ID boundary of the 5-stage MIPS pipeline.
- Presents the PC to the synchronous instruction SRAM and captures the returned word.
- Delivers instrD (op/funct/rs/rt fields) to the main decoder, together with pcD, pc_plus4D, the delay-slot flag and the fetch address-error flag.
- Handles stalls, branch/jump redirects, flushes and exception redirects.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word presented in D for bubbles and faulting fetches.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stallF  in  1  hold pcF.
- stallD  in  1  hold the IF/ID contents.
- flushD  in  1  turn the D slot into a bubble on the next edge.
- branch_takenD  in  1  the branch resolved in D is taken.
- branch_targetD  in  32  target of the taken branch.
- jumpD  in  1  j/jal/jr/jalr in D.
- jump_targetD  in  32  target of the jump.
- is_bjD  in  1  the D instruction is any branch/jump (decoder branch|j|jal|jr|jalr).
- exc_flush  in  1  exception/eret redirect from the CP0 stage.
- exc_pc  in  32  redirect target (exception vector or EPC).
- inst_sram_en  out  1  instruction SRAM read enable.
- inst_sram_addr  out  32  instruction SRAM address (= pcF).
- inst_sram_rdata  in  32  read data, valid one cycle after the address.
- pcF  out  32  current fetch PC.
- instrD  out  32  instruction word to the decoder.
- pcD  out  32  PC of instrD.
- pc_plus4D  out  32  pcD + 4.
- validD  out  1  the D slot holds a real instruction.
- in_dsD  out  1  instrD is in a branch delay slot.
- adelD  out  1  fetch address error (pcD[1:0] != 0).

Behaviour:
- Reset (async, rst=1):
  - pcF = RESET_PC.
  - pcD = 0, pc_plus4D = 0.
  - validD = 0, in_dsD = 0, adelD = 0.
  - Hold register and hold_valid cleared.
  - instrD = NOP_WORD.
  - inst_sram_en = 0 while rst is high.
- Next-PC priority, evaluated at each edge:
  1. exc_flush → exc_pc.
  2. stallF → pcF unchanged.
  3. jumpD → jump_targetD.
  4. branch_takenD → branch_targetD.
  5. Otherwise pcF + 4, with 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- SRAM interface:
  - inst_sram_addr = pcF, combinational.
  - inst_sram_en = ~rst & (pcF[1:0] == 0). A misaligned fetch never touches memory.
- IF/ID register update, at each edge:
  - exc_flush or flushD: validD = 0, in_dsD = 0, adelD = 0, hold cleared. Applies even if stallD = 1; flush wins over stall.
  - Else if stallD: pcD, pc_plus4D, validD, in_dsD and adelD are held.
  - Else (advance):
    - pcD = pcF, pc_plus4D = pcF + 4.
    - validD = 1, adelD = (pcF[1:0] != 0).
    - in_dsD = is_bjD & validD (the instruction leaving D was a branch/jump).
- Instruction hold buffer (the SRAM returns data for pcD only in the first D cycle):
  - First cycle of stallD with hold_valid = 0: capture inst_sram_rdata into hold, set hold_valid.
  - Any cycle with stallD = 0, or a flush: clear hold_valid.
- instrD is selected with this priority:
  1. NOP_WORD if ~validD or adelD.
  2. Otherwise hold if hold_valid.
  3. Otherwise inst_sram_rdata.
- Latency: pcF in cycle n → instrD and pcD in cycle n+1, when unstalled.
- Simultaneous events:
  - stallF with exc_flush: pcF takes exc_pc.
  - jumpD with branch_takenD: jump target wins.
  - A redirect arriving while stallF = 1 is ignored. Hazard control must hold the branch in D (stallD) until stallF drops.

Test Plan:
- Reset release → first edge pcF = 32'hBFC0_0000. Edge 2: pcD = BFC0_0000, instrD = SRAM word, pcF = BFC0_0004.
- stallF = stallD = 1 for 3 cycles with SRAM rdata changing → instrD stays the word captured in the first stall cycle; pcF and pcD are constant. After release the sequence resumes without skipping or duplicating an instruction.
- BEQ at pcD = BFC0_0010 with branch_takenD = 1, target BFC0_0100 → next pcD = BFC0_0014 with in_dsD = 1, then pcD = BFC0_0100 with in_dsD = 0.
- exc_flush = 1 with exc_pc = BFC0_0380 during a stall → pcF = BFC0_0380, validD = 0, instrD = 0. The next cycle fetches 0380.
- jump_targetD = BFC0_0202 → inst_sram_en = 0; the following D cycle shows adelD = 1, instrD = 0, pcD = BFC0_0202.
- flushD and stallD asserted together → validD = 0 and hold_valid cleared on that edge.
